// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: memCtrl codes, FSM
// states and small decode helpers used by the sequencer and lane logic.
package lsu_pkg;

    localparam logic [2:0] MEM_LB  = 3'b000;
    localparam logic [2:0] MEM_LH  = 3'b001;
    localparam logic [2:0] MEM_LW  = 3'b010;
    localparam logic [2:0] MEM_LBU = 3'b011;
    localparam logic [2:0] MEM_LHU = 3'b100;
    localparam logic [2:0] MEM_SB  = 3'b101;
    localparam logic [2:0] MEM_SH  = 3'b110;
    localparam logic [2:0] MEM_SW  = 3'b111;

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} lsu_state_t;

    // Why the sequencer went to ERR; selects which pulse fires there.
    typedef enum logic {CAUSE_MISALIGN, CAUSE_TIMEOUT} lsu_cause_t;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} lsu_size_t;

    // Direction comes from the code alone, never from memRd/memWR.
    function automatic logic is_store(input logic [2:0] mem_ctrl);
        return (mem_ctrl == MEM_SB) || (mem_ctrl == MEM_SH) || (mem_ctrl == MEM_SW);
    endfunction

    function automatic lsu_size_t op_size(input logic [2:0] mem_ctrl);
        case (mem_ctrl)
            MEM_LB, MEM_LBU, MEM_SB: return SZ_BYTE;
            MEM_LH, MEM_LHU, MEM_SH: return SZ_HALF;
            default:                 return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [2:0] mem_ctrl, input logic [1:0] off);
        case (op_size(mem_ctrl))
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~off[0];
            default: return (off == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_sequencer_if.sv
// req/ack data-memory bus between the load/store sequencer (master) and
// the memory side (slave).
interface lsu_sequencer_if #(
    parameter int XLEN = 32
) ();
    logic            busReq;
    logic            busWE;
    logic [XLEN-1:0] busAddr;
    logic [XLEN-1:0] busWdata;
    logic [3:0]      busBe;
    logic            busAck;
    logic [XLEN-1:0] busRdata;

    modport master (
        output busReq, busWE, busAddr, busWdata, busBe,
        input  busAck, busRdata
    );

    modport slave (
        input  busReq, busWE, busAddr, busWdata, busBe,
        output busAck, busRdata
    );
endinterface

// File: rtl/lsu_lane.sv
// Byte-lane steering: store-side byte enables and lane-replicated write
// data, and load-side lane selection with sign/zero extension. Purely
// combinational so other datapaths (e.g. a cache fill) can share it.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  i_st_ctrl,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  logic [2:0]  i_ld_ctrl,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Enables and write data by access size; loads use the same enables.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case leaves it unassigned and infers a latch.
        o_be    = 4'b1111;
        o_wdata = i_st_data;
        case (op_size(i_st_ctrl))
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_st_off;
                o_wdata = {4{i_st_data[7:0]}};
            end
            SZ_HALF: begin
                o_be    = i_st_off[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Pick the addressed byte/half of the returned word and extend it.
    always_comb begin
        w_byte = i_ld_word[7:0];
        case (i_ld_off)
            2'd1:    w_byte = i_ld_word[15:8];
            2'd2:    w_byte = i_ld_word[23:16];
            2'd3:    w_byte = i_ld_word[31:24];
            default: ;
        endcase
        w_half = i_ld_off[1] ? i_ld_word[31:16] : i_ld_word[15:0];

        o_ld_data = i_ld_word;
        case (i_ld_ctrl)
            MEM_LB:  o_ld_data = {{24{w_byte[7]}}, w_byte};
            MEM_LH:  o_ld_data = {{16{w_half[15]}}, w_half};
            MEM_LBU: o_ld_data = {24'b0, w_byte};
            MEM_LHU: o_ld_data = {16'b0, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_sequencer.sv
// Multi-cycle load/store sequencer. Latches one access from the execute
// stage, runs a single req/ack bus transaction, stalls the pipeline until
// it finishes and reports completion, misalignment or bus timeout as
// one-cycle pulses.
module lsu_sequencer
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRd,
    input  logic              memWR,
    input  logic [2:0]        memCtrl,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              stall,
    output logic              done,
    output logic [XLEN-1:0]   rdata,
    output logic              misalign,
    output logic              timeout,
    lsu_sequencer_if.master   bus
);

    lsu_state_t      r_state;
    lsu_state_t      w_next;
    lsu_cause_t      r_cause;
    logic [2:0]      r_ctrl;
    logic [1:0]      r_off;
    logic [XLEN-1:0] r_bus_addr;
    logic [XLEN-1:0] r_wdata;
    logic [3:0]      r_be;
    logic            r_we;
    logic [TO_W-1:0] r_cnt;
    logic [XLEN-1:0] r_rdata;

    logic            w_start;
    logic            w_aligned;
    logic            w_last;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_ld_data;

    assign w_start   = memRd | memWR;
    assign w_aligned = is_aligned(memCtrl, addr[1:0]);
    assign w_last    = (r_cnt == TO_W'(TIMEOUT - 1));

    // Store lanes come from the live request; load lanes from the latched one.
    lsu_lane u_lane (
        .i_st_ctrl (memCtrl),
        .i_st_off  (addr[1:0]),
        .i_st_data (wdata),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .i_ld_ctrl (r_ctrl),
        .i_ld_off  (r_off),
        .i_ld_word (bus.busRdata),
        .o_ld_data (w_ld_data)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of block ordering.
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state and control outputs; reset gates stall off immediately.
    always_comb begin
        w_next     = r_state;
        stall      = 1'b0;
        done       = 1'b0;
        misalign   = 1'b0;
        timeout    = 1'b0;
        bus.busReq = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start && !rst) begin
                    stall  = 1'b1;
                    w_next = w_aligned ? REQ : ERR;
                end
            end
            REQ: begin
                stall      = 1'b1;
                bus.busReq = 1'b1;
                if (bus.busAck)  w_next = DONE;
                else if (w_last) w_next = ERR;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            ERR: begin
                misalign = (r_cause == CAUSE_MISALIGN);
                timeout  = (r_cause == CAUSE_TIMEOUT);
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request capture, wait counter, error cause and load result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cause    <= CAUSE_MISALIGN;
            r_ctrl     <= MEM_LB;
            r_off      <= 2'b00;
            r_bus_addr <= '0;
            r_wdata    <= '0;
            r_be       <= 4'b0000;
            r_we       <= 1'b0;
            r_cnt      <= '0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_start) begin
                        r_ctrl     <= memCtrl;
                        r_off      <= addr[1:0];
                        r_bus_addr <= {addr[XLEN-1:2], 2'b00};
                        r_wdata    <= w_wdata;
                        r_be       <= w_be;
                        r_we       <= is_store(memCtrl);
                        r_cause    <= CAUSE_MISALIGN;
                    end
                end
                REQ: begin
                    r_cnt <= r_cnt + TO_W'(1);
                    if (bus.busAck) begin
                        if (!r_we) r_rdata <= w_ld_data;
                    end else if (w_last) begin
                        r_cause <= CAUSE_TIMEOUT;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign bus.busWE    = r_we && (r_state == REQ);
    assign bus.busAddr  = r_bus_addr;
    assign bus.busWdata = r_wdata;
    assign bus.busBe    = r_be;
    assign rdata        = r_rdata;

endmodule
